// File: rtl/time_set_controller.sv
// Manual time-setting controller: debounces the mode/inc buttons, runs the
// RUN -> SET_H -> SET_M -> COMMIT sequence and drives load, run_en and blink enables.

module time_set_btn_cond #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic level
);
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                cnt   <= '0;
                level <= sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module time_set_controller #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_RATE     = 5000000,
    parameter int unsigned BLINK_HALF      = 12500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [7:0] cur_hrs,
    input  logic [7:0] cur_mins,
    output logic [7:0] set_hrs,
    output logic [7:0] set_mins,
    output logic       load,
    output logic       run_en,
    output logic       blink_hrs,
    output logic       blink_mins,
    output logic [1:0] mode
);
    localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RW      = $clog2(REP_MAX + 1);
    localparam int unsigned BW      = $clog2(BLINK_HALF + 1);

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        SET_H  = 2'b01,
        SET_M  = 2'b10,
        COMMIT = 2'b11
    } state_t;

    state_t        state, next_state;
    logic          mode_level, mode_level_q, inc_level, inc_level_q;
    logic          mode_press, inc_press, inc_evt, rep_hit, set_state, rep_keep;
    logic          blink_clr, blink_phase, repeating;
    logic [RW-1:0] rep_cnt;
    logic [BW-1:0] blink_cnt;
    logic [7:0]    hrs_nxt, mins_nxt;

    time_set_btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_cond (
        .clk(clk), .reset(reset), .btn(btn_mode), .level(mode_level)
    );
    time_set_btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc_cond (
        .clk(clk), .reset(reset), .btn(btn_inc), .level(inc_level)
    );

    function automatic logic [7:0] sanitize_hrs(input logic [7:0] v);
        if (v[7:4] > 4'd2 || v[3:0] > 4'd9 || (v[7:4] == 4'd2 && v[3:0] > 4'd3))
            return '0;
        return v;
    endfunction

    function automatic logic [7:0] sanitize_mins(input logic [7:0] v);
        if (v[7:4] > 4'd5 || v[3:0] > 4'd9)
            return '0;
        return v;
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
        if (v == top)         return '0;
        if (v[3:0] == 4'd9)   return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    assign mode_press = mode_level & ~mode_level_q;
    assign inc_press  = inc_level & ~inc_level_q;
    assign set_state  = (state == SET_H) || (state == SET_M);
    assign rep_hit    = inc_level && (rep_cnt == (repeating ? RW'(REPEAT_RATE) : RW'(REPEAT_DELAY)));
    assign inc_evt    = set_state && (inc_press || rep_hit);

    always_comb begin
        next_state = state;
        hrs_nxt    = set_hrs;
        mins_nxt   = set_mins;
        blink_clr  = 1'b0;
        unique case (state)
            RUN: if (mode_press) begin
                next_state = SET_H;
                hrs_nxt    = sanitize_hrs(cur_hrs);
                mins_nxt   = sanitize_mins(cur_mins);
                blink_clr  = 1'b1;
            end
            SET_H: if (mode_press) begin
                next_state = SET_M;
                blink_clr  = 1'b1;
            end else if (inc_evt) begin
                hrs_nxt   = bcd_inc(set_hrs, 8'h23);
                blink_clr = 1'b1;
            end
            SET_M: if (mode_press) begin
                next_state = COMMIT;
            end else if (inc_evt) begin
                mins_nxt  = bcd_inc(set_mins, 8'h59);
                blink_clr = 1'b1;
            end
            COMMIT: next_state = RUN;
            default: next_state = RUN;
        endcase
    end

    // Repeat timing only survives while inc stays held within one SET state.
    assign rep_keep = set_state && inc_level && (next_state == state);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= RUN;
            set_hrs      <= '0;
            set_mins     <= '0;
            mode_level_q <= 1'b0;
            inc_level_q  <= 1'b0;
            rep_cnt      <= '0;
            repeating    <= 1'b0;
            blink_cnt    <= '0;
            blink_phase  <= 1'b0;
        end else begin
            state        <= next_state;
            set_hrs      <= hrs_nxt;
            set_mins     <= mins_nxt;
            mode_level_q <= mode_level;
            inc_level_q  <= inc_level;
            if (!rep_keep) begin
                rep_cnt   <= '0;
                repeating <= 1'b0;
            end else if (inc_evt) begin
                rep_cnt   <= RW'(1);
                repeating <= ~inc_press;
            end else begin
                rep_cnt <= rep_cnt + 1'b1;
            end
            if (blink_clr) begin
                blink_cnt   <= '0;
                blink_phase <= 1'b0;
            end else if (blink_cnt == BW'(BLINK_HALF - 1)) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    assign mode       = state;
    assign load       = (state == COMMIT);
    assign run_en     = (state == RUN);
    assign blink_hrs  = blink_phase && (state == SET_H);
    assign blink_mins = blink_phase && (state == SET_M);
endmodule
